// File: rtl/mem_pkg.sv
// Shared types for the load/store access controller.
// funct3 width codes, state encoding and a validity helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  function automatic logic f3_valid(input logic [2:0] f);
    return (f == F3_B) || (f == F3_H) || (f == F3_W) ||
           (f == F3_BU) || (f == F3_HU);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-side bundle of the access controller.
// slave is the controller view, master the requester/memory view.
interface mem_access_ctrl_if;

  logic        req;
  logic        wr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  req, wr, funct3, addr, wdata, mem_rd,
    output rdata, done, busy, err,
    output mem_addr, mem_din, mem_we
  );

  modport master (
    output req, wr, funct3, addr, wdata, mem_rd,
    input  rdata, done, busy, err,
    input  mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/mem_access_ctrl_load_ext.sv
// Load lane select and sign/zero extension.
// Byte lane by lane_i, half lane by lane_i[1].
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word_i[{lane_i, 3'b000} +: 8];
  assign h = word_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = word_i;
    unique case (1'b1)
      (funct3_i == F3_B):  data_o = {{24{b[7]}}, b};
      (funct3_i == F3_BU): data_o = {24'h0, b};
      (funct3_i == F3_H):  data_o = {{16{h[15]}}, h};
      (funct3_i == F3_HU): data_o = {16'h0, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// RV32I load/store controller with read-modify-write for sub-word stores.
// MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input logic clk,
  input logic rst,
  mem_access_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [MEM_AW+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [31:0]       ext;
  logic [31:0]       merged;
  logic              mis;
  logic              unused_addr;

  assign unused_addr = ^bus.addr[31:MEM_AW+2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = ((bus.funct3[1:0] == SZ_H) && bus.addr[0]) ||
               ((bus.funct3[1:0] == SZ_W) && (bus.addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  load_ext u_ext (
    .word_i   (bus.mem_rd),
    .lane_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ext)
  );

  always_comb begin
    merged = merge_q;
    unique case (1'b1)
      (f3_q[1:0] == SZ_B):
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      (f3_q[1:0] == SZ_H):
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr[MEM_AW+1:0];
          wdata_d = bus.wdata;
          f3_d    = bus.funct3;
          wr_d    = bus.wr;
          err_d   = 1'b0;
          if (!f3_valid(bus.funct3) || mis) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (bus.wr && bus.funct3[1:0] == SZ_W) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (wr_q) begin
          merge_d = bus.mem_rd;
          state_d = WRITE;
        end else begin
          rdata_d = ext;
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // mem_we decodes straight from state so reset kills it asynchronously
  assign bus.mem_we   = (state_q == WRITE);
  assign bus.mem_din  = (state_q != WRITE) ? 32'h0 :
                        (f3_q[1:0] == SZ_W) ? wdata_q : merged;
  assign bus.mem_addr = (state_q == IDLE) ? 32'h0 :
                        {{(30-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
  assign bus.done     = (state_q == DONE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.err      = (state_q == DONE) && err_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 1024-word memory model.
// Covers loads, sub-word RMW stores, errors, held req and mid-write reset.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.MEM_AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          we_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] first_addr;

  assign bus.mem_rd = mem[bus.mem_addr[9:0]];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_din;
      we_cnt <= we_cnt + 1;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic run(input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit hold, output int lat,
                     output logic e, output int nwe);
    int w0;
    w0 = we_cnt;
    bus.req    = 1'b1;
    bus.wr     = w;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.wdata  = d;
    @(posedge clk);
    #1;
    if (!hold) bus.req = 1'b0;
    lat = 1;
    first_addr = bus.mem_addr;
    while (!bus.done && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.done) chk("timeout", 32'd0, 32'd1);
    e = bus.err;
    bus.req = 1'b0;
    nwe = we_cnt - w0;
    @(posedge clk);
    #1;
  endtask

  int   lat;
  logic e;
  int   nwe;

  initial begin
    bus.req    = 1'b0;
    bus.wr     = 1'b0;
    bus.funct3 = 3'b000;
    bus.addr   = '0;
    bus.wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_flags", {29'h0, bus.done, bus.busy, bus.err}, 32'h0);
    chk("rst_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_din", bus.mem_din, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    poke(10'd5, 32'h8070_F0A5);

    run(1'b0, 3'b000, 32'h14, 32'h0, 1'b0, lat, e, nwe);
    chk("lb_data", bus.rdata, 32'hFFFF_FFA5);
    chk("lb_lat", lat, 32'd2);
    chk("lb_err", {31'h0, e}, 32'h0);
    chk("lb_maddr", first_addr, 32'd5);
    run(1'b0, 3'b101, 32'h16, 32'h0, 1'b0, lat, e, nwe);
    chk("lhu_data", bus.rdata, 32'h0000_8070);
    run(1'b0, 3'b001, 32'h16, 32'h0, 1'b0, lat, e, nwe);
    chk("lh_data", bus.rdata, 32'hFFFF_8070);
    run(1'b0, 3'b100, 32'h15, 32'h0, 1'b0, lat, e, nwe);
    chk("lbu_data", bus.rdata, 32'h0000_00F0);
    run(1'b0, 3'b000, 32'h17, 32'h0, 1'b0, lat, e, nwe);
    chk("lb3_data", bus.rdata, 32'hFFFF_FF80);
    run(1'b0, 3'b001, 32'h14, 32'h0, 1'b0, lat, e, nwe);
    chk("lh0_data", bus.rdata, 32'hFFFF_F0A5);
    run(1'b0, 3'b010, 32'h14, 32'h0, 1'b0, lat, e, nwe);
    chk("lw_data", bus.rdata, 32'h8070_F0A5);
    chk("lw_lat", lat, 32'd2);

    run(1'b1, 3'b000, 32'h15, 32'h0000_0033, 1'b0, lat, e, nwe);
    chk("sb_we", nwe, 32'd1);
    chk("sb_lat", lat, 32'd3);
    chk("sb_mem", mem[5], 32'h8070_33A5);
    chk("sb_rhold", bus.rdata, 32'h8070_F0A5);
    run(1'b1, 3'b001, 32'h16, 32'h0000_1234, 1'b0, lat, e, nwe);
    chk("sh_mem", mem[5], 32'h1234_33A5);
    chk("sh_lat", lat, 32'd3);
    run(1'b0, 3'b010, 32'h14, 32'h0, 1'b0, lat, e, nwe);
    chk("lw_back", bus.rdata, 32'h1234_33A5);

    run(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b1, lat, e, nwe);
    chk("sw_maddr", first_addr, 32'd8);
    chk("sw_mem", mem[8], 32'hDEAD_BEEF);
    chk("sw_we", nwe, 32'd1);
    chk("sw_lat", lat, 32'd2);
    chk("sw_idle", {31'h0, bus.busy}, 32'h0);

    run(1'b0, 3'b011, 32'h14, 32'h0, 1'b0, lat, e, nwe);
    chk("bad_err", {31'h0, e}, 32'h1);
    chk("bad_lat", lat, 32'd1);
    chk("bad_we", nwe, 32'd0);
    chk("bad_rhold", bus.rdata, 32'h1234_33A5);
    chk("err_clr", {31'h0, bus.err}, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
    run(1'b1, 3'b010, 32'h22, 32'hCAFE_F00D, 1'b0, lat, e, nwe);
    chk("mis_err", {31'h0, e}, 32'h1);
    chk("mis_we", nwe, 32'd0);
    chk("mis_mem", mem[8], 32'hDEAD_BEEF);
    chk("mis_rhold", bus.rdata, 32'h1234_33A5);
`else
    run(1'b1, 3'b010, 32'h22, 32'hCAFE_F00D, 1'b0, lat, e, nwe);
    chk("mis_err", {31'h0, e}, 32'h0);
    chk("mis_we", nwe, 32'd1);
    chk("mis_mem", mem[8], 32'hCAFE_F00D);
    run(1'b1, 3'b001, 32'h17, 32'h0000_ABCD, 1'b0, lat, e, nwe);
    chk("mish_mem", mem[5], 32'hABCD_33A5);
`endif

    poke(10'd9, 32'hAABB_CCDD);
    nwe = we_cnt;
    bus.req    = 1'b1;
    bus.wr     = 1'b1;
    bus.funct3 = 3'b001;
    bus.addr   = 32'h24;
    bus.wdata  = 32'h0000_5555;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_we_on", {31'h0, bus.mem_we}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rw_we_off", {31'h0, bus.mem_we}, 32'h0);
    chk("rw_din", bus.mem_din, 32'h0);
    chk("rw_rdata", bus.rdata, 32'h0);
    chk("rw_flags", {29'h0, bus.done, bus.busy, bus.err}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rw_mem", mem[9], 32'hAABB_CCDD);
    chk("rw_nwe", we_cnt - nwe, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
